// File: rtl/vga_timing_gen.sv
// Raster timing generator for a 640x480@60 display: pixel/line counters, visible-area
// qualifier and sync pulses delayed to match image-ROM latency, plus frame markers.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 2
) (
    input  logic        pix_clk,
    input  logic        rst,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        bright,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_W  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hcount_r;
    logic [9:0]  vcount_r;
    logic        line_start_r;
    logic        frame_start_r;
    logic [15:0] frame_count_r;

    logic        h_last_s;
    logic        v_last_s;
    logic        bright_raw_s;
    logic        hsync_raw_s;
    logic        vsync_raw_s;

    // Wrap detection and undelayed visible/sync decode from the registered counts
    always_comb begin
        h_last_s     = (hcount_r == H_LAST);
        v_last_s     = (vcount_r == V_LAST);
        bright_raw_s = (hcount_r < H_VIS_W) && (vcount_r < V_VIS_W);
        if ((hcount_r >= HS_START) && (hcount_r < HS_END)) begin
            hsync_raw_s = SYNC_ACTIVE;
        end else begin
            hsync_raw_s = ~SYNC_ACTIVE;
        end
        if ((vcount_r >= VS_START) && (vcount_r < VS_END)) begin
            vsync_raw_s = SYNC_ACTIVE;
        end else begin
            vsync_raw_s = ~SYNC_ACTIVE;
        end
    end

    // Raster counters, line/frame markers and completed-frame counter
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            hcount_r      <= 10'd0;
            vcount_r      <= 10'd0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            // Markers are set on the wrapping edge so they coincide with count 0
            line_start_r  <= h_last_s;
            frame_start_r <= h_last_s && v_last_s;
            if (h_last_s) begin
                hcount_r <= 10'd0;
                if (v_last_s) begin
                    vcount_r      <= 10'd0;
                    frame_count_r <= frame_count_r + 16'd1;
                end else begin
                    vcount_r <= vcount_r + 10'd1;
                end
            end else begin
                hcount_r <= hcount_r + 10'd1;
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign bright = bright_raw_s;
            assign hsync  = hsync_raw_s;
            assign vsync  = vsync_raw_s;
        end else begin : g_pipe
            logic [PIPE_DELAY-1:0] bright_pipe_r;
            logic [PIPE_DELAY-1:0] hsync_pipe_r;
            logic [PIPE_DELAY-1:0] vsync_pipe_r;

            // Shift raw decode through PIPE_DELAY stages to align with ROM pixel data
            always_ff @(posedge pix_clk or posedge rst) begin
                if (rst) begin
                    bright_pipe_r <= '0;
                    hsync_pipe_r  <= {PIPE_DELAY{~SYNC_ACTIVE}};
                    vsync_pipe_r  <= {PIPE_DELAY{~SYNC_ACTIVE}};
                end else begin
                    bright_pipe_r[0] <= bright_raw_s;
                    hsync_pipe_r[0]  <= hsync_raw_s;
                    vsync_pipe_r[0]  <= vsync_raw_s;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        bright_pipe_r[i] <= bright_pipe_r[i-1];
                        hsync_pipe_r[i]  <= hsync_pipe_r[i-1];
                        vsync_pipe_r[i]  <= vsync_pipe_r[i-1];
                    end
                end
            end

            assign bright = bright_pipe_r[PIPE_DELAY-1];
            assign hsync  = hsync_pipe_r[PIPE_DELAY-1];
            assign vsync  = vsync_pipe_r[PIPE_DELAY-1];
        end
    endgenerate

    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance (PIPE_DELAY=2) for line timing, plus a tiny
// 8x7-cycle raster instance (PIPE_DELAY=0) so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

    logic        pix_clk = 1'b0;
    logic        rst     = 1'b1;

    logic [9:0]  hcount_a, vcount_a, hcount_b, vcount_b;
    logic        bright_a, hsync_a, vsync_a, line_start_a, frame_start_a;
    logic        bright_b, hsync_b, vsync_b, line_start_b, frame_start_b;
    logic [15:0] frame_count_a, frame_count_b;

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_gen dut_a (
        .pix_clk(pix_clk), .rst(rst),
        .hcount(hcount_a), .vcount(vcount_a),
        .bright(bright_a), .hsync(hsync_a), .vsync(vsync_a),
        .line_start(line_start_a), .frame_start(frame_start_a),
        .frame_count(frame_count_a)
    );

    // Small raster: H 4+1+2+1 = 8, V 3+1+1+2 = 7, 56 cycles per frame
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(0)
    ) dut_b (
        .pix_clk(pix_clk), .rst(rst),
        .hcount(hcount_b), .vcount(vcount_b),
        .bright(bright_b), .hsync(hsync_b), .vsync(vsync_b),
        .line_start(line_start_b), .frame_start(frame_start_b),
        .frame_count(frame_count_b)
    );

    always #20 pix_clk = ~pix_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int cyc;
        int a_hsync_low;
        int b_bright_cnt;
        int b_vsync_low;
        int b_pulses;
        int h, v;

        a_hsync_low  = 0;
        b_bright_cnt = 0;
        b_vsync_low  = 0;
        b_pulses     = 0;

        rst = 1'b1;
        repeat (3) @(negedge pix_clk);
        check_eq("rst_hcount_a", int'(hcount_a), 0);
        check_eq("rst_vcount_a", int'(vcount_a), 0);
        check_eq("rst_bright_a", int'(bright_a), 0);
        check_eq("rst_hsync_a", int'(hsync_a), 1);
        check_eq("rst_vsync_a", int'(vsync_a), 1);
        check_eq("rst_line_start_a", int'(line_start_a), 0);
        check_eq("rst_frame_start_a", int'(frame_start_a), 0);
        check_eq("rst_frame_count_a", int'(frame_count_a), 0);

        rst = 1'b0;
        for (int c = 0; c <= 800; c++) begin
            check_eq("a_hcount", int'(hcount_a), (c < 800) ? c : 0);
            check_eq("a_vcount", int'(vcount_a), (c < 800) ? 0 : 1);
            check_eq("a_line_start", int'(line_start_a), (c == 800) ? 1 : 0);
            check_eq("a_frame_start", int'(frame_start_a), 0);
            check_eq("a_hsync", int'(hsync_a), (c >= 658 && c <= 753) ? 0 : 1);
            check_eq("a_bright", int'(bright_a), (c >= 2 && c <= 641) ? 1 : 0);
            check_eq("a_vsync", int'(vsync_a), 1);
            if (c < 800 && hsync_a == 1'b0) a_hsync_low++;

            h = c % 8;
            v = (c / 8) % 7;
            check_eq("b_hcount", int'(hcount_b), h);
            check_eq("b_vcount", int'(vcount_b), v);
            check_eq("b_bright", int'(bright_b), (h < 4 && v < 3) ? 1 : 0);
            check_eq("b_hsync", int'(hsync_b), (h == 5 || h == 6) ? 0 : 1);
            check_eq("b_vsync", int'(vsync_b), (v == 4) ? 0 : 1);
            check_eq("b_line_start", int'(line_start_b), (c > 0 && h == 0) ? 1 : 0);
            check_eq("b_frame_start", int'(frame_start_b), (c > 0 && c % 56 == 0) ? 1 : 0);
            check_eq("b_frame_count", int'(frame_count_b), c / 56);
            if (c >= 56 && c < 112) begin
                b_bright_cnt += int'(bright_b);
                if (vsync_b == 1'b0) b_vsync_low++;
            end
            if (c <= 168) begin
                b_pulses += int'(frame_start_b);
            end
            if (c == 168) begin
                check_eq("b_fc_after_3_frames", int'(frame_count_b), 3);
            end
            @(negedge pix_clk);
        end
        cyc = 801;

        check_eq("a_hsync_low_per_line", a_hsync_low, 96);
        check_eq("b_bright_per_frame", b_bright_cnt, 12);
        check_eq("b_vsync_low_per_frame", b_vsync_low, 8);
        check_eq("b_pulses_3_frames", b_pulses, 3);

        // Preload the frame counter just short of rollover; next wrap at cycle 840
        force dut_b.frame_count_r = 16'hFFFF;
        @(negedge pix_clk);
        cyc++;
        release dut_b.frame_count_r;
        check_eq("b_fc_preload", int'(frame_count_b), 65535);
        while (cyc < 840) begin
            @(negedge pix_clk);
            cyc++;
        end
        check_eq("b_fc_rollover", int'(frame_count_b), 0);
        check_eq("b_frame_start_rollover", int'(frame_start_b), 1);

        while (cyc < 1100) begin
            @(negedge pix_clk);
            cyc++;
        end
        check_eq("a_mid_hcount", int'(hcount_a), 300);
        check_eq("a_mid_vcount", int'(vcount_a), 1);
        check_eq("a_mid_bright", int'(bright_a), 1);

        rst = 1'b1;
        #1;
        check_eq("async_hcount_a", int'(hcount_a), 0);
        check_eq("async_vcount_a", int'(vcount_a), 0);
        check_eq("async_bright_a", int'(bright_a), 0);
        check_eq("async_hsync_a", int'(hsync_a), 1);
        check_eq("async_vsync_a", int'(vsync_a), 1);
        check_eq("async_frame_count_a", int'(frame_count_a), 0);
        check_eq("async_frame_count_b", int'(frame_count_b), 0);
        check_eq("async_hcount_b", int'(hcount_b), 0);

        @(negedge pix_clk);
        @(negedge pix_clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("post_rst_hcount_a", int'(hcount_a), k);
            check_eq("post_rst_vcount_a", int'(vcount_a), 0);
            check_eq("post_rst_bright_a", int'(bright_a), (k >= 2) ? 1 : 0);
            check_eq("post_rst_line_start_a", int'(line_start_a), 0);
            @(negedge pix_clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
